// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the ALU arbiter:
//     - state_t          : arbiter FSM state encoding
//     - TIMEOUT_RESULT   : all-ones word returned when the ALU never answers;
//                          users take the low DW bits, so DW is limited to 64
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [63:0] TIMEOUT_RESULT = '1;

endpackage : alu_arb_pkg

// File: rtl/alu_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Finds the first set request bit at or
//   above ptr, wrapping around past N-1 back to 0.
//
//   Ports:
//     req     in   N    request levels
//     ptr     in   IW   highest-priority index (0..N-1)
//     onehot  out  N    one-hot winner, all-zero when no request
//     idx     out  IW   binary winner index, 0 when no request
//     any     out  1    at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // NOTE: every variable assigned in this block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        // Doubling the vector turns the wrap-around search into a plain shift:
        // rot[k] is the request of requester (ptr + k) mod N.
        req2 = {req, req};
        rot  = N'(req2 >> ptr);
        any  = 1'b0;
        sum  = '0;
        // Scan downward so the lowest offset (closest to ptr) is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IW + 1)'(k);
            end
        end
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx    = sum[IW-1:0];
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule : rr_pick

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU (start/done controller + datapath) among N requesters.
//   A round-robin picker selects an owner, whose opcode and operands are
//   latched at grant; the owner keeps the ALU until its result is returned
//   with a one-cycle acknowledge.
//
//   Sequence: IDLE -> ISSUE (start held until done) -> RELEASE (start low,
//   wait for done to fall) -> RESP (ack pulse, pointer advance) -> IDLE.
//
//   Optional build macro:
//     ALU_ARB_TIMEOUT_EN  adds a TO_CYCLES watchdog on ISSUE; on expiry the
//                         operation is forced to complete with an all-ones
//                         result and the extra `timeout` output pulses with ack.
//
//   Ports:
//     clk         in   1       clock, rising edge
//     reset_a     in   1       asynchronous reset, active low
//     req         in   N       per-requester request level
//     op_in       in   N*OPW   opcodes, requester i at [i*OPW +: OPW]
//     a_in        in   N*DW    operand A, requester i at [i*DW +: DW]
//     b_in        in   N*DW    operand B, requester i at [i*DW +: DW]
//     gnt         out  N       one-hot ALU owner, zero when idle
//     ack         out  N       one-cycle one-hot result-valid pulse
//     result      out  DW      registered result, held after ack
//     alu_start   out  1       level start to the ALU controller
//     alu_op      out  OPW     latched opcode
//     alu_a       out  DW      latched operand A
//     alu_b       out  DW      latched operand B
//     alu_done    in   1       done from the ALU controller
//     alu_result  in   DW      ALU result, valid while alu_done is high
//     busy        out  1       high whenever not IDLE
//     timeout     out  1       (ALU_ARB_TIMEOUT_EN only) pulses with ack on
//                              a watchdog-forced completion
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int OPW       = 3,
    parameter int TO_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset_a,
    input  logic [N-1:0]     req,
    input  logic [N*OPW-1:0] op_in,
    input  logic [N*DW-1:0]  a_in,
    input  logic [N*DW-1:0]  b_in,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [DW-1:0]    result,
    output logic             alu_start,
    output logic [OPW-1:0]   alu_op,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    input  logic             alu_done,
    input  logic [DW-1:0]    alu_result,
    output logic             busy
`ifdef ALU_ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int IW = $clog2(N);

    // Reject configurations the datapath was not built for.
    if (N < 2 || N > 8 || DW < 1 || DW > $bits(TIMEOUT_RESULT) || TO_CYCLES < 1)
    begin : g_param_check
        $error("alu_arbiter: parameter out of range");
    end

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner_idx;
    logic [IW-1:0]   ptr_next;
    logic [DW-1:0]   res_q;

    logic [N-1:0]    pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [OPW-1:0]  sel_op;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0]   to_cnt;
    logic            to_flag;
`endif

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Operand/opcode slice of the current picker winner.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_onehot[i]) begin
                sel_op = op_in[i*OPW +: OPW];
                sel_a  = a_in[i*DW +: DW];
                sel_b  = b_in[i*DW +: DW];
            end
        end
    end

    // Pointer moves to the requester just after the finishing owner.
    always_comb begin
        ptr_next = (owner_idx == IW'(N - 1)) ? '0 : owner_idx + IW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner_idx <= '0;
            res_q     <= '0;
            gnt       <= '0;
            ack       <= '0;
            result    <= '0;
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            busy      <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            to_flag   <= 1'b0;
            timeout   <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        gnt       <= pick_onehot;
                        owner_idx <= pick_idx;
                        alu_op    <= sel_op;
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
`ifdef ALU_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
                        to_flag   <= 1'b0;
`endif
                    end
                end

                S_ISSUE: begin
                    // A done already high on entry is accepted here at once.
                    if (alu_done) begin
                        res_q     <= alu_result;
                        alu_start <= 1'b0;
                        state     <= S_RELEASE;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (to_cnt == TW'(TO_CYCLES - 1)) begin
                        res_q     <= TIMEOUT_RESULT[DW-1:0];
                        alu_start <= 1'b0;
                        to_flag   <= 1'b1;
                        state     <= S_RELEASE;
                    end else begin
                        to_cnt    <= to_cnt + TW'(1);
                    end
`endif
                end

                S_RELEASE: begin
                    // Wait out a done that lingers after start has dropped so
                    // it cannot be mistaken for the next operation's done.
                    if (!alu_done) begin
                        ack    <= gnt;
                        result <= res_q;
                        state  <= S_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
                        timeout <= to_flag;
`endif
                    end
                end

                S_RESP: begin
                    ptr   <= ptr_next;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter (N=4, DW=8, OPW=3, TO_CYCLES=4). A small
//   behavioural ALU controller answers one cycle after start, optionally
//   keeps done high for an extra cycle after start drops, or stays mute.
//   Define ALU_ARB_TIMEOUT_EN to also exercise the watchdog path.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int OPW = 3;

    logic                clk = 1'b0;
    logic                reset_a = 1'b0;
    logic [N-1:0]        req = '0;
    logic [N*OPW-1:0]    op_in = '0;
    logic [N*DW-1:0]     a_in = '0;
    logic [N*DW-1:0]     b_in = '0;
    logic [N-1:0]        gnt;
    logic [N-1:0]        ack;
    logic [DW-1:0]       result;
    logic                alu_start;
    logic [OPW-1:0]      alu_op;
    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic                alu_done;
    logic [DW-1:0]       alu_result;
    logic                busy;
`ifdef ALU_ARB_TIMEOUT_EN
    logic                timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Requester table: op, A, B and the hand-computed result.
    logic [OPW-1:0] tab_op  [N] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [DW-1:0]  tab_a   [N] = '{8'h0F, 8'h05, 8'h10, 8'hAA};
    logic [DW-1:0]  tab_b   [N] = '{8'h3C, 8'h03, 8'h01, 8'h0F};
    logic [DW-1:0]  tab_res [N] = '{8'h0C, 8'h08, 8'h0F, 8'hA5};

    always #5 clk = ~clk;

    alu_arbiter #(
        .N         (N),
        .DW        (DW),
        .OPW       (OPW),
        .TO_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_a    (reset_a),
        .req        (req),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .ack        (ack),
        .result     (result),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .busy       (busy)
`ifdef ALU_ARB_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    // Behavioural ALU controller: 0=and 1=add 2=sub 3=xor others=or.
    logic [3:0] alu_cnt   = '0;
    logic       linger_q  = 1'b0;
    logic       linger_en = 1'b0;
    logic       mute      = 1'b0;

    function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!alu_start) alu_cnt <= '0;
        else if (alu_cnt != 4'hF) alu_cnt <= alu_cnt + 4'd1;
        linger_q <= linger_en && alu_start && (alu_cnt >= 4'd1);
    end

    assign alu_done   = !mute && ((alu_start && (alu_cnt >= 4'd1)) || linger_q);
    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_slice(input int i, input logic [OPW-1:0] op,
                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_in[i*OPW +: OPW] = op;
        a_in[i*DW +: DW]    = a;
        b_in[i*DW +: DW]    = b;
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) load_slice(i, tab_op[i], tab_a[i], tab_b[i]);
    endtask

    task automatic do_reset();
        reset_a = 1'b0;
        tick();
        tick();
        reset_a = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int exp_i;

        load_table();

        // ---- reset state ----
        tick();
        tick();
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_start", alu_start, 0);
        check("rst_result", result, 0);
        check("rst_alu_a", alu_a, 0);
        reset_a = 1'b1;
        tick();

        // ---- asynchronous reset while in ISSUE ----
        req = 4'b0001;
        tick();
        check("mid_start_pre", alu_start, 1);
        reset_a = 1'b0;
        req     = 4'b0000;
        #1;
        check("mid_start", alu_start, 0);
        check("mid_gnt", gnt, 0);
        check("mid_busy", busy, 0);
        tick();
        reset_a = 1'b1;
        tick();
        tick();
        check("mid_idle_busy", busy, 0);
        check("mid_idle_gnt", gnt, 0);
        check("mid_idle_ack", ack, 0);

        // ---- single request, operand change after grant, owner drops req ----
        req = 4'b0010;
        tick();                                   // edge 1: grant
        check("one_gnt", gnt, 4'b0010);
        check("one_alu_a", alu_a, 8'h05);
        check("one_alu_b", alu_b, 8'h03);
        check("one_alu_op", alu_op, 3'd1);
        check("one_busy", busy, 1);
        a_in[1*DW +: DW] = 8'hFF;
        req = 4'b0000;
        tick();                                   // edge 2: ISSUE
        check("one_ack_e2", ack, 0);
        check("one_start_e2", alu_start, 1);
        tick();                                   // edge 3: RELEASE
        check("one_start_e3", alu_start, 0);
        check("one_alu_a_held", alu_a, 8'h05);
        tick();                                   // edge 4: RESP
        check("one_ack", ack, 4'b0010);
        check("one_result", result, 8'h08);
        tick();                                   // edge 5: IDLE
        check("one_busy_end", busy, 0);
        check("one_ack_end", ack, 0);
        check("one_result_hold", result, 8'h08);

        // ---- all requesting: rotation from pointer 0 ----
        load_table();
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            exp_i = n % N;
            w = 0;
            while (gnt == 0 && w < 10) begin tick(); w++; end
            check("rr_gnt", gnt, 32'(1) << exp_i);
            w = 0;
            while (ack == 0 && w < 10) begin tick(); w++; end
            check("rr_ack", ack, 32'(1) << exp_i);
            check("rr_result", result, tab_res[exp_i]);
            tick();
            check("rr_ack_gap", ack, 0);
            check("rr_gnt_gap", gnt, 0);
        end
        req = 4'b0000;

        // ---- done lingers one cycle after start falls ----
        linger_en = 1'b1;
        req = 4'b0100;
        tick();                                   // edge 1: grant
        check("lin_gnt", gnt, 4'b0100);
        tick();                                   // edge 2
        tick();                                   // edge 3: RELEASE
        check("lin_start_e3", alu_start, 0);
        check("lin_ack_e3", ack, 0);
        tick();                                   // edge 4: still RELEASE
        check("lin_ack_e4", ack, 0);
        check("lin_gnt_e4", gnt, 4'b0100);
        check("lin_busy_e4", busy, 1);
        tick();                                   // edge 5: RESP
        check("lin_ack", ack, 4'b0100);
        check("lin_result", result, 8'h0F);
        tick();                                   // edge 6: IDLE
        check("lin_ack_once", ack, 0);
        check("lin_gnt_idle", gnt, 0);
        tick();                                   // edge 7: lone requester again
        check("lin_regrant", gnt, 4'b0100);
        req = 4'b0000;
        w = 0;
        while (ack == 0 && w < 12) begin tick(); w++; end
        check("lin_ack2", ack, 4'b0100);
        tick();
        check("lin_ack2_end", ack, 0);
        linger_en = 1'b0;

`ifdef ALU_ARB_TIMEOUT_EN
        // ---- watchdog: ALU never answers (pointer is now 3) ----
        mute = 1'b1;
        req  = 4'b1001;
        tick();                                   // edge 1: grant requester 3
        check("to_gnt", gnt, 4'b1000);
        tick();
        tick();
        tick();                                   // edge 4: still waiting
        check("to_start_e4", alu_start, 1);
        check("to_ack_e4", ack, 0);
        tick();                                   // edge 5: forced RELEASE
        check("to_start_e5", alu_start, 0);
        check("to_ack_e5", ack, 0);
        tick();                                   // edge 6: RESP
        check("to_ack", ack, 4'b1000);
        check("to_flag", timeout, 1);
        check("to_result", result, 8'hFF);
        mute = 1'b0;
        tick();                                   // edge 7: IDLE
        check("to_flag_end", timeout, 0);
        check("to_gnt_idle", gnt, 0);
        tick();                                   // edge 8: next requester
        check("to_next_gnt", gnt, 4'b0001);
        req = 4'b0000;
        w = 0;
        while (ack == 0 && w < 10) begin tick(); w++; end
        check("to_next_ack", ack, 4'b0001);
        check("to_next_result", result, tab_res[0]);
        check("to_next_flag", timeout, 0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_arbiter
